// File: rtl/m_shift_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_shift_sched_pkg                                            |
// | Description : Shared types and helpers for the MArray shift scheduler:     |
// |               shifter modes, operand precisions, FSM encoding and the      |
// |               per-precision pass list lookup.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package m_shift_sched_pkg;

  // Nibble significance of the shifted product: {weight nibble, activation nibble}
  typedef enum logic [1:0] {
    SM_LL = 2'b00,
    SM_LH = 2'b01,
    SM_HL = 2'b10,
    SM_HH = 2'b11
  } shift_mode_e;

  // Operand precision: weight x activation
  typedef enum logic [1:0] {
    P4x4 = 2'b00,
    P8x4 = 2'b01,
    P4x8 = 2'b10,
    P8x8 = 2'b11
  } prec_e;

  // Scheduler states
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  // Number of nibble passes one tile needs at a given precision
  function automatic logic [2:0] pass_count(input prec_e prec);
    case (prec)
      P4x4:       pass_count = 3'd1;
      P8x4, P4x8: pass_count = 3'd2;
      default:    pass_count = 3'd4;
    endcase
  endfunction

  // Shifter mode of pass number idx within a tile; the low-low pass is always first
  function automatic shift_mode_e pass_mode(input prec_e prec, input logic [1:0] idx);
    case (prec)
      P4x4:    pass_mode = SM_LL;
      P8x4:    pass_mode = idx[0] ? SM_HL : SM_LL;
      P4x8:    pass_mode = idx[0] ? SM_LH : SM_LL;
      default: pass_mode = shift_mode_e'(idx);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_shift_sched_tag_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_shift_tag_delay                                            |
// | Description : Fixed-latency valid+tag shift register. Never stalls, so a   |
// |               tag launched on issue always reaches the accumulator stage;  |
// |               the asynchronous reset flushes every in-flight entry.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module m_shift_tag_delay #(
  parameter int W   = 2,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_tag,
  output logic         out_valid,
  output logic [W-1:0] out_tag
);

  logic [LAT-1:0]        r_vld;
  logic [LAT-1:0][W-1:0] r_tag;

  // Shift valid and tag one stage per cycle; stage 0 takes the new entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      r_vld[0] <= in_valid;
      r_tag[0] <= in_tag;
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign out_tag   = r_tag[LAT-1];

endmodule
`default_nettype wire

// File: rtl/m_shift_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_shift_sched                                                |
// | Description : Shifter-stage sequencer. Walks the nibble-significance       |
// |               passes of every tile in a job, one pass per accepted cycle,  |
// |               and delays a {first,last} tag by the MAC+shift pipeline      |
// |               depth to drive accumulator clear/enable/last.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module m_shift_sched
  import m_shift_sched_pkg::*;
#(
  parameter int PIPE_LAT = 2,
  parameter int TILE_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_prec,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic              arr_ready,
  output logic              issue_valid,
  output logic [1:0]        shift_mode,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              acc_last,
  output logic              tile_done,
  output logic              busy,
  output logic              done
);

  localparam int                c_dw        = $clog2(PIPE_LAT + 1);
  localparam logic [c_dw-1:0]   c_drain_end = c_dw'(PIPE_LAT - 1);
  localparam logic [c_dw-1:0]   c_drain_one = c_dw'(1);
  localparam logic [TILE_W-1:0] c_tile_one  = TILE_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  prec_e             r_prec;
  logic [TILE_W-1:0] r_tiles;
  logic [TILE_W-1:0] r_tile_cnt;
  logic [1:0]        r_pass_idx;
  logic [c_dw-1:0]   r_drain_cnt;
  shift_mode_e       r_last_mode;

  shift_mode_e       w_cur_mode;
  logic [2:0]        w_npass;
  logic              w_pass_first;
  logic              w_pass_last;
  logic              w_tile_last;
  logic              w_accept;
  logic              w_fire;
  logic              w_tag_vld;
  logic [1:0]        w_tag;

  assign w_cur_mode   = pass_mode(r_prec, r_pass_idx);
  assign w_npass      = pass_count(r_prec);
  assign w_pass_first = (r_pass_idx == 2'd0);
  assign w_pass_last  = ({1'b0, r_pass_idx} == (w_npass - 3'd1));
  assign w_tile_last  = (r_tile_cnt == (r_tiles - c_tile_one));
  assign w_accept     = (r_state == c_st_idle) && cfg_valid;
  assign w_fire       = (r_state == c_st_run) && arr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state: empty jobs skip straight to DONE; the last pass of the last tile starts the drain
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (cfg_valid) w_state_nxt = (cfg_tiles == '0) ? c_st_done : c_st_run;
      c_st_run:   if (w_fire && w_pass_last && w_tile_last) w_state_nxt = c_st_drain;
      c_st_drain: if (r_drain_cnt == c_drain_end) w_state_nxt = c_st_done;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Job latch, pass/tile counters, drain timer and the mode held while nothing is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prec      <= P4x4;
      r_tiles     <= '0;
      r_tile_cnt  <= '0;
      r_pass_idx  <= 2'd0;
      r_drain_cnt <= '0;
      r_last_mode <= SM_LL;
    end else begin
      if (w_accept) begin
        r_prec     <= prec_e'(cfg_prec);
        r_tiles    <= cfg_tiles;
        r_tile_cnt <= '0;
        r_pass_idx <= 2'd0;
      end else if (w_fire) begin
        r_last_mode <= w_cur_mode;
        if (w_pass_last) begin
          r_pass_idx <= 2'd0;
          r_tile_cnt <= r_tile_cnt + c_tile_one;
        end else begin
          r_pass_idx <= r_pass_idx + 2'd1;
        end
      end
      if (r_state == c_st_drain) r_drain_cnt <= r_drain_cnt + c_drain_one;
      else                       r_drain_cnt <= '0;
    end
  end

  // State-decoded outputs; outside RUN the shifter keeps seeing the last issued mode
  always_comb begin
    cfg_ready   = (r_state == c_st_idle);
    issue_valid = (r_state == c_st_run);
    busy        = (r_state == c_st_run) || (r_state == c_st_drain);
    done        = (r_state == c_st_done);
    shift_mode  = (r_state == c_st_run) ? w_cur_mode : r_last_mode;
  end

  m_shift_tag_delay #(
    .W   (2),
    .LAT (PIPE_LAT)
  ) u_tag_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_fire),
    .in_tag    ({w_pass_first, w_pass_last}),
    .out_valid (w_tag_vld),
    .out_tag   (w_tag)
  );

  assign acc_en    = w_tag_vld;
  assign acc_clear = w_tag_vld & w_tag[1];
  assign acc_last  = w_tag_vld & w_tag[0];
  assign tile_done = acc_last;

endmodule
`default_nettype wire
